mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter for a single line-wide memory port.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin contention, else requester 1 wins.
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req0,
  input  logic                  rd_req1,
  input  logic                  wr_req0,
  input  logic                  wr_req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [BLOCK_SIZE-1:0] wdata0,
  input  logic [BLOCK_SIZE-1:0] wdata1,
  output logic [BLOCK_SIZE-1:0] rdata0,
  output logic [BLOCK_SIZE-1:0] rdata1,
  output logic                  done0,
  output logic                  done1,
  output logic                  read_en_mem,
  output logic                  write_en_mem,
  output logic [ADDR_WIDTH-1:0] addr_mem,
  output logic [BLOCK_SIZE-1:0] data_in_mem,
  input  logic [BLOCK_SIZE-1:0] data_out_mem,
  input  logic                  valid_mem,
  input  logic                  ready_mem,
  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic req0, req1, any_req;
  logic winner;
  logic winner_wr;
  logic op_write;
  logic complete;

  assign req0    = rd_req0 | wr_req0;
  assign req1    = rd_req1 | wr_req1;
  assign any_req = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Requester granted most recently; reset to 1 so the first contention goes to 0.
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst)                 last_grant <= 1'b1;
    else if (state == DONE)  last_grant <= grant;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    winner = 1'b0;
    if (req0 && req1) winner = ~last_grant;
    else              winner = req1;
  end
`else
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = 1'b1;
    else              winner = req1;
  end
`endif

  // A write-back takes priority over a refill from the same requester.
  assign winner_wr = winner ? wr_req1 : wr_req0;

  // Memory handshake is only meaningful for the strobe matching the latched op.
  assign complete = (state == BUSY) && (op_write ? ready_mem : valid_mem);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req)  state_nxt = BUSY;
      BUSY:    if (complete) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction capture at the grant edge; requests changing afterwards have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= 1'b0;
      op_write    <= 1'b0;
      addr_mem    <= '0;
      data_in_mem <= '0;
    end else if (state == IDLE && any_req) begin
      grant       <= winner;
      op_write    <= winner_wr;
      addr_mem    <= winner ? addr1 : addr0;
      data_in_mem <= winner_wr ? (winner ? wdata1 : wdata0) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (complete && !op_write) begin
      if (grant) rdata1 <= data_out_mem;
      else       rdata0 <= data_out_mem;
    end
  end

  assign read_en_mem  = (state == BUSY) && !op_write;
  assign write_en_mem = (state == BUSY) &&  op_write;
  assign done0        = (state == DONE) && !grant;
  assign done1        = (state == DONE) &&  grant;
  assign busy         = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant, op selection and refill data.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req0, rd_req1, wr_req0, wr_req1;
  logic [AW-1:0] addr0, addr1;
  logic [BW-1:0] wdata0, wdata1;
  logic [BW-1:0] rdata0, rdata1;
  logic          done0, done1;
  logic          read_en_mem, write_en_mem;
  logic [AW-1:0] addr_mem;
  logic [BW-1:0] data_in_mem;
  logic [BW-1:0] data_out_mem;
  logic          valid_mem, ready_mem;
  logic          grant, busy;

  mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_SIZE(BW)) dut (
    .clk(clk), .rst(rst),
    .rd_req0(rd_req0), .rd_req1(rd_req1), .wr_req0(wr_req0), .wr_req1(wr_req1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .done0(done0), .done1(done1),
    .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
    .addr_mem(addr_mem), .data_in_mem(data_in_mem), .data_out_mem(data_out_mem),
    .valid_mem(valid_mem), .ready_mem(ready_mem), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: last requester served and the refill line each side should hold.
  int            last_w = 1;
  logic [BW-1:0] exp_rdata [2];

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pick_winner(input bit want0, input bit want1);
    if (want0 && want1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return (last_w == 1) ? 0 : 1;
`else
      return 1;
`endif
    end
    return want1 ? 1 : 0;
  endfunction

  task automatic clear_reqs();
    rd_req0 = 1'b0; wr_req0 = 1'b0; rd_req1 = 1'b0; wr_req1 = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata0"}, rdata0, '0);
    check({tag, "_rdata1"}, rdata1, '0);
    check({tag, "_done0"}, done0, 0);
    check({tag, "_done1"}, done1, 0);
    check({tag, "_rd_en"}, read_en_mem, 0);
    check({tag, "_wr_en"}, write_en_mem, 0);
    check({tag, "_addr_mem"}, addr_mem, '0);
    check({tag, "_data_in"}, data_in_mem, '0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Runs one transaction from an idle negedge to the negedge after the DONE cycle.
  task automatic run_txn(input bit r0, input bit w0, input bit r1, input bit w1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [BW-1:0] d0, input logic [BW-1:0] d1,
                         input logic [BW-1:0] mdata, input int lat, input bit drop);
    int            win;
    bit            is_wr;
    logic [AW-1:0] exp_addr;
    logic [BW-1:0] exp_wd;

    rd_req0 = r0; wr_req0 = w0; rd_req1 = r1; wr_req1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    valid_mem = 1'b0; ready_mem = 1'b0;

    if (!(r0 | w0 | r1 | w1)) begin
      @(negedge clk);
      check("noreq_busy", busy, 0);
      check("noreq_rd_en", read_en_mem, 0);
      return;
    end

    win      = pick_winner(r0 | w0, r1 | w1);
    is_wr    = (win == 1) ? w1 : w0;
    exp_addr = (win == 1) ? a1 : a0;
    exp_wd   = (win == 1) ? d1 : d0;

    @(negedge clk);
    check("grant_busy", busy, 1);
    check("grant_idx", grant, win[0]);
    check("grant_rd_en", read_en_mem, !is_wr);
    check("grant_wr_en", write_en_mem, is_wr);
    check("grant_addr_mem", addr_mem, exp_addr);
    if (is_wr) check("grant_data_in", data_in_mem, exp_wd);

    if (drop) begin
      clear_reqs();
      addr0 = $urandom; addr1 = $urandom;
      wdata0 = rand_line(); wdata1 = rand_line();
    end

    for (int i = 0; i < lat; i++) begin
      data_out_mem = rand_line();
      valid_mem    = is_wr ? 1'($urandom % 2) : 1'b0;
      ready_mem    = is_wr ? 1'b0 : 1'($urandom % 2);
      @(negedge clk);
      check("wait_busy", busy, 1);
      check("wait_rd_en", read_en_mem, !is_wr);
      check("wait_wr_en", write_en_mem, is_wr);
      check("wait_addr_mem", addr_mem, exp_addr);
      if (is_wr) check("wait_data_in", data_in_mem, exp_wd);
      check("wait_done0", done0, 0);
      check("wait_done1", done1, 0);
    end

    data_out_mem = mdata;
    valid_mem    = is_wr ? 1'($urandom % 2) : 1'b1;
    ready_mem    = is_wr ? 1'b1 : 1'($urandom % 2);
    if (!is_wr) exp_rdata[win] = mdata;

    @(negedge clk);
    check("done_busy", busy, 1);
    check("done_pulse0", done0, win == 0);
    check("done_pulse1", done1, win == 1);
    check("done_rd_en", read_en_mem, 0);
    check("done_wr_en", write_en_mem, 0);
    check("done_rdata0", rdata0, exp_rdata[0]);
    check("done_rdata1", rdata1, exp_rdata[1]);
    last_w = win;

    // Memory strobes and requests during DONE must change nothing.
    valid_mem = 1'b1; ready_mem = 1'b1; data_out_mem = rand_line();
    rd_req0 = 1'($urandom % 2); wr_req0 = 1'($urandom % 2);
    rd_req1 = 1'($urandom % 2); wr_req1 = 1'($urandom % 2);

    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_done0", done0, 0);
    check("post_done1", done1, 0);
    check("post_rdata0", rdata0, exp_rdata[0]);
    check("post_rdata1", rdata1, exp_rdata[1]);
    clear_reqs();
    valid_mem = 1'b0; ready_mem = 1'b0;
  endtask

  task automatic reset_mid_read();
    rd_req0 = 1'b1; addr0 = 32'h0000_1234;
    @(negedge clk);
    check("rstmid_busy", busy, 1);
    check("rstmid_rd_en", read_en_mem, 1);
    clear_reqs();
    rst = 1'b1; valid_mem = 1'b1; data_out_mem = rand_line();
    @(negedge clk);
    check_all_zero("rstmid");
    rst = 1'b0;
    @(negedge clk);
    check("rstafter_busy", busy, 0);
    check("rstafter_done0", done0, 0);
    check("rstafter_rdata0", rdata0, '0);
    valid_mem = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_w = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_reqs();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    data_out_mem = '0; valid_mem = 1'b0; ready_mem = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Refill for requester 0, valid three cycles after the grant edge.
    run_txn(1, 0, 0, 0, 32'h0000_0040, '0, '0, '0,
            128'hFAAABEEF_55667788_11223344_AABBCCDD, 2, 0);
    // Write-back from requester 1, accepted after two cycles.
    run_txn(0, 0, 0, 1, '0, 32'h0000_0C0C, '0,
            128'h11112222_33334444_55556666_77778888, rand_line(), 2, 0);
    // Read and write together from requester 0: serviced as a write.
    run_txn(1, 1, 0, 0, 32'h0000_0080, '0, rand_line(), '0, rand_line(), 3, 0);
    // Requester 1 drops its read and changes its address after the grant.
    run_txn(0, 0, 1, 0, '0, 32'h0000_0100, '0, '0, rand_line(), 2, 1);

    reset_mid_read();

    // Sustained contention: 0,1,0,1 with round-robin, 1,1,1,1 otherwise.
    for (int k = 0; k < 4; k++)
      run_txn(1, 0, 1, 0, $urandom, $urandom, '0, '0, rand_line(), k, 0);

    for (int k = 0; k < 250; k++)
      run_txn(1'($urandom % 2), 1'($urandom % 4 == 0), 1'($urandom % 2), 1'($urandom % 4 == 0),
              $urandom, $urandom, rand_line(), rand_line(), rand_line(),
              $urandom_range(0, 4), 1'($urandom % 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
